// File: rtl/ctext_word_buffer_pkg.sv
// Shared types for the AES ciphertext output path: word type, sequencer states, byte swap helper.
package aes_out_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } out_state_t;

  localparam int unsigned WORD_BYTES = 4;

  function automatic word_t byte_swap(input word_t w);
    word_t r;
    r = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      r[8*i +: 8] = w[8*(WORD_BYTES-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ctext_word_buffer_word_fifo.sv
// Synchronous show-ahead FIFO with push/pop, occupancy count and synchronous flush.
module word_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;
  logic             full;

  // Pop on empty is silently ignored.
  assign do_pop = pop && (count != '0);
  assign full   = (count == CW'(DEPTH));
  assign head   = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (n_rst && !flush) begin
      assert (!(push && !do_pop && full)) else $error("word_fifo: push on full");
    end
  end

endmodule

// File: rtl/ctext_word_buffer.sv
// Sequences the 128->32 output shift register into a word FIFO read by the host.
// Optional macro CTEXT_BYTE_SWAP_EN: byte-reverse each word on push for a little-endian host.
module ctext_word_buffer
  import aes_out_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned WORDS_PER_BLOCK = 4
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              block_valid,
  output logic                              block_ready,
  input  logic                              flush,
  output logic                              sr_load,
  output logic                              sr_shift,
  input  logic [31:0]                       sr_word,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic [31:0]                       word_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned      CNT_W     = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W-1:0] SPACE_LIM = CNT_W'(FIFO_DEPTH - WORDS_PER_BLOCK);
  localparam logic [1:0]       LAST_IDX  = 2'(WORDS_PER_BLOCK - 1);

  out_state_t state, state_n;
  logic [1:0] word_idx, word_idx_n;
  logic       push;
  word_t      push_data;

`ifdef CTEXT_BYTE_SWAP_EN
  assign push_data = byte_swap(sr_word);
`else
  assign push_data = sr_word;
`endif

  assign word_valid = (fifo_count != '0);

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(word_t))
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (word_valid && word_ready),
    .head      (word_data),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      word_idx <= '0;
    end else begin
      state    <= state_n;
      word_idx <= word_idx_n;
    end
  end

  // Space for a whole block is reserved at the handshake, so DRAIN never stalls.
  // block_ready is gated by n_rst because it is combinational from the count.
  always_comb begin
    state_n     = state;
    word_idx_n  = word_idx;
    block_ready = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    push        = 1'b0;
    if (flush) begin
      state_n    = IDLE;
      word_idx_n = '0;
    end else begin
      case (state)
        IDLE: begin
          block_ready = n_rst && (fifo_count <= SPACE_LIM);
          if (block_valid && block_ready) begin
            sr_load    = 1'b1;
            state_n    = DRAIN;
            word_idx_n = '0;
          end
        end
        DRAIN: begin
          sr_shift   = 1'b1;
          push       = 1'b1;
          word_idx_n = word_idx + 2'd1;
          if (word_idx == LAST_IDX) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctext_word_buffer.sv
// Scoreboard bench for ctext_word_buffer with a behavioural 128->32 shift register model.
module tb_ctext_word_buffer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        block_valid;
  logic        block_ready;
  logic        flush;
  logic        sr_load;
  logic        sr_shift;
  logic [31:0] sr_word;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [3:0]  fifo_count;

  logic [127:0] blk_data;
  logic [127:0] sr;
  logic [31:0]  exp_q [$];
  int           n_vec = 0;
  int           n_err = 0;
  int           n_load = 0;
  int           n_shift = 0;
  int           n_both = 0;

  always #5 clk = ~clk;

  ctext_word_buffer #(.FIFO_DEPTH(8), .WORDS_PER_BLOCK(4)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .flush       (flush),
    .sr_load     (sr_load),
    .sr_shift    (sr_shift),
    .sr_word     (sr_word),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .fifo_count  (fifo_count)
  );

  always @(posedge clk) begin
    if (sr_load)       sr <= blk_data;
    else if (sr_shift) sr <= {sr[95:0], 32'h0};
  end
  assign sr_word = sr[127:96];

  function automatic logic [31:0] host_word(input logic [31:0] w);
`ifdef CTEXT_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Host-side monitor: each accepted word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (n_rst) begin
      if (sr_load) n_load++;
      if (sr_shift) n_shift++;
      if (sr_load && sr_shift) n_both++;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else check("word_data", word_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [127:0] d);
    bit got = 0;
    blk_data    = d;
    block_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (block_ready) got = 1;
    end
    if (!got) begin
      check("handshake_timeout", 32'(got), 32'd1);
      block_valid = 1'b0;
    end else begin
      tick();
      block_valid = 1'b0;
      exp_q.push_back(host_word(d[127:96]));
      exp_q.push_back(host_word(d[95:64]));
      exp_q.push_back(host_word(d[63:32]));
      exp_q.push_back(host_word(d[31:0]));
    end
  endtask

  task automatic drain_all();
    bit done = 0;
    word_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (fifo_count == 0 && exp_q.size() == 0) done = 1;
    end
    check("drain_timeout", 32'(done), 32'd1);
    tick();
    word_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sh0;
    n_rst = 1'b0; block_valid = 1'b1; flush = 1'b0; word_ready = 1'b1;
    blk_data = '0;

    // 1: reset holds everything low even with block_valid asserted
    repeat (3) @(negedge clk);
    check("rst_block_ready", 32'(block_ready), 32'd0);
    check("rst_word_valid",  32'(word_valid),  32'd0);
    check("rst_word_data",   word_data,        32'd0);
    check("rst_fifo_count",  32'(fifo_count),  32'd0);
    check("rst_sr_load",     32'(sr_load),     32'd0);
    check("rst_sr_shift",    32'(sr_shift),    32'd0);
    block_valid = 1'b0;
    tick();
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_block_ready", 32'(block_ready), 32'd1);
    check("idle_fifo_count",  32'(fifo_count),  32'd0);

    // 2: single block, host always ready
    tick();
    n_load = 0; n_shift = 0;
    send_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
    @(negedge clk);
    check("lat_not_yet", 32'(word_valid), 32'd0);
    @(negedge clk);
    check("lat_first_word", 32'(word_valid), 32'd1);
    drain_all();
    check("single_loads",  32'(n_load),  32'd1);
    check("single_shifts", 32'(n_shift), 32'd4);

    // 3: backpressure fills the FIFO, then frees one block of space
    word_ready = 1'b0;
    send_block(128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
    send_block(128'h10203040_50607080_90A0B0C0_D0E0F000);
    repeat (4) tick();
    @(negedge clk);
    check("full_count", 32'(fifo_count), 32'd8);
    tick();
    block_valid = 1'b1;
    blk_data = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    @(negedge clk);
    check("full_block_ready", 32'(block_ready), 32'd0);
    check("full_no_load",     32'(sr_load),     32'd0);
    tick();
    block_valid = 1'b0;
    word_ready = 1'b1;
    repeat (4) tick();
    word_ready = 1'b0;
    @(negedge clk);
    check("after_pop_count", 32'(fifo_count),  32'd4);
    check("after_pop_ready", 32'(block_ready), 32'd1);
    drain_all();

    // 4: push and pop together keep the count steady
    send_block(128'h01020304_05060708_090A0B0C_0D0E0F10);
    repeat (4) tick();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    @(negedge clk);
    check("pp_pre_count", 32'(fifo_count), 32'd3);
    tick();
    send_block(128'hFFEEDDCC_BBAA9988_77665544_33221100);
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pp_count", 32'(fifo_count), 32'd3);
      tick();
    end
    drain_all();

    // 5: flush in the second DRAIN cycle discards the block
    n_shift = 0;
    send_block(128'h11111111_22222222_33333333_44444444);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush_sr_shift",    32'(sr_shift),    32'd0);
    check("flush_block_ready", 32'(block_ready), 32'd0);
    tick();
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_count",       32'(fifo_count),  32'd0);
    check("flush_word_valid",  32'(word_valid),  32'd0);
    check("flush_idle_ready",  32'(block_ready), 32'd1);
    sh0 = n_shift;
    repeat (5) tick();
    check("flush_no_shift", 32'(n_shift - sh0), 32'd0);

    // 6: asynchronous reset mid-DRAIN with five words stored
    send_block(128'hCAFEF00D_12345678_9ABCDEF0_0BADC0DE);
    repeat (4) tick();
    send_block(128'h55555555_66666666_77777777_88888888);
    tick();
    check("pre_rst_count", 32'(fifo_count), 32'd5);
    n_rst = 1'b0;
    #1;
    check("arst_count",      32'(fifo_count),  32'd0);
    check("arst_word_valid", 32'(word_valid),  32'd0);
    check("arst_word_data",  word_data,        32'd0);
    check("arst_sr_shift",   32'(sr_shift),    32'd0);
    check("arst_ready",      32'(block_ready), 32'd0);
    exp_q.delete();
    tick();
    n_rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(block_ready), 32'd1);
    tick();
    send_block(128'h89ABCDEF_01234567_FEDCBA98_76543210);
    drain_all();

    check("load_shift_overlap", 32'(n_both), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
